// File: rtl/ym3438_slot_sequencer_if.sv
// Debug-read handshake bundle between the slot sequencer and its requester.
// The requester drives dbg_req/dbg_slot; the sequencer returns the chain timing strobes and status.
interface ym3438_slot_sequencer_if;
   logic       dbg_req;
   logic [4:0] dbg_slot;
   logic       dbg_load;
   logic       dbg_shift;
   logic       dbg_busy;
   logic       dbg_done;
   logic       dbg_err;

   modport master (
      output dbg_req, dbg_slot,
      input  dbg_load, dbg_shift, dbg_busy, dbg_done, dbg_err
   );

   modport slave (
      input  dbg_req, dbg_slot,
      output dbg_load, dbg_shift, dbg_busy, dbg_done, dbg_err
   );
endinterface

// File: rtl/ym3438_slot_sequencer.sv
// OPN2 master phase divider (c1/c2), 24-slot frame counter and debug-chain read scheduler.
// Every state element runs on MCLK; c1/c2 are enables, never clocks.
module ym3438_slot_sequencer #(
   parameter int CLK_DIV   = 6,
   parameter int SLOTS     = 24,
   parameter int DBG_WIDTH = 10
) (
   input  logic                          MCLK,
   input  logic                          IC,
   output logic                          c1,
   output logic                          c2,
   output logic [4:0]                    slot,
   output logic                          sync,
   ym3438_slot_sequencer_if.slave        dbg
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int CW = $clog2(DBG_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   logic [PW-1:0] p;
   logic [4:0]    slot_next;
   logic [4:0]    target;
   logic [CW-1:0] cnt;
   logic          req_q;
   logic          err_flag;
   logic          c2_tick;
   state_t        state;

   // The prescaler rests at 0 during reset, so the enables are masked by IC to stay low there.
   assign c2_tick   = (p == PW'(CLK_DIV / 2));
   assign c1        = IC & (p == '0);
   assign c2        = IC & c2_tick;
   assign slot_next = (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
   assign sync      = (slot == 5'(SLOTS - 1));

   always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         p    <= '0;
         slot <= 5'd0;
      end else begin
         p <= (p == PW'(CLK_DIV - 1)) ? '0 : p + 1'b1;
         if (c2_tick) begin
            slot <= slot_next;
         end
      end
   end

   // A target equal to the current slot is only matched on its next occurrence a frame later.
   always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         state    <= S_IDLE;
         req_q    <= 1'b0;
         target   <= 5'd0;
         cnt      <= '0;
         err_flag <= 1'b0;
      end else begin
         req_q <= dbg.dbg_req;
         case (state)
            S_IDLE: begin
               if (dbg.dbg_req && !req_q) begin
                  if ({1'b0, dbg.dbg_slot} < 6'(SLOTS)) begin
                     target <= dbg.dbg_slot;
                     state  <= S_WAIT;
                  end else begin
                     err_flag <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end
            S_WAIT: begin
               if (c2_tick && (slot_next == target)) begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (c2_tick) begin
                  cnt   <= '0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (c2_tick) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(DBG_WIDTH - 1)) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               err_flag <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign dbg.dbg_load  = (state == S_LOAD);
   assign dbg.dbg_shift = (state == S_SHIFT);
   assign dbg.dbg_busy  = (state != S_IDLE);
   assign dbg.dbg_done  = (state == S_DONE);
   assign dbg.dbg_err   = (state == S_DONE) && err_flag;

endmodule

// File: tb/tb_ym3438_slot_sequencer.sv
// Directed bench for ym3438_slot_sequencer: phase/slot timing, debug-read windows, reject, ignore and abort.
// A free-running MCLK count since reset release drives the reference model of c1/c2/slot.
module tb_ym3438_slot_sequencer;
   localparam int CLK_DIV   = 6;
   localparam int SLOTS     = 24;
   localparam int DBG_WIDTH = 10;

   logic       MCLK = 1'b0;
   logic       IC   = 1'b0;
   logic       c1, c2, sync;
   logic [4:0] slot;

   ym3438_slot_sequencer_if dbg_bus ();

   ym3438_slot_sequencer #(
      .CLK_DIV  (CLK_DIV),
      .SLOTS    (SLOTS),
      .DBG_WIDTH(DBG_WIDTH)
   ) dut (
      .MCLK(MCLK),
      .IC  (IC),
      .c1  (c1),
      .c2  (c2),
      .slot(slot),
      .sync(sync),
      .dbg (dbg_bus)
   );

   always #5 MCLK = ~MCLK;

   int compared   = 0;
   int mismatched = 0;
   int mcount;
   logic [DBG_WIDTH-1:0] chain;

   // Cycle k is the MCLK period closed by edge k; the chain model loads on c1 and shifts on c2.
   always @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         mcount <= 0;
         chain  <= '0;
      end else begin
         mcount <= mcount + 1;
         if (dbg_bus.dbg_load && c1) chain <= 10'h2B3;
         else if (dbg_bus.dbg_shift && c2) chain <= chain >> 1;
      end
   end

   function automatic int exp_slot(input int k);
      return ((k + CLK_DIV / 2 - 1) / CLK_DIV) % SLOTS;
   endfunction

   function automatic int first_load(input int k0, input int tgt);
      for (int k = k0 + 2; k < k0 + 2000; k++) begin
         if ((k % CLK_DIV == CLK_DIV / 2 + 1) && (exp_slot(k) == tgt)) return k;
      end
      return -1;
   endfunction

   int load_first, slot_at_load, load_cnt, shift_first, shift_cnt;
   int done_cnt, done_cycle, err_cnt, bit_idx;
   logic [DBG_WIDTH-1:0] bits;

   task automatic observe(input int n, input bit inject);
      load_first = -1; slot_at_load = -1; load_cnt = 0; shift_first = -1; shift_cnt = 0;
      done_cnt = 0; done_cycle = -1; err_cnt = 0; bit_idx = 0; bits = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge MCLK);
         if (dbg_bus.dbg_load) begin
            if (load_first < 0) begin
               load_first   = mcount;
               slot_at_load = int'(slot);
            end
            load_cnt++;
         end
         if (dbg_bus.dbg_shift) begin
            if (shift_first < 0) shift_first = mcount;
            shift_cnt++;
            if (c1 && bit_idx < DBG_WIDTH) begin
               bits[bit_idx] = chain[0];
               bit_idx++;
            end
         end
         if (dbg_bus.dbg_done) begin
            done_cnt++;
            done_cycle = mcount;
         end
         if (dbg_bus.dbg_err) err_cnt++;
         if (inject) begin
            if (shift_cnt == 18 && dbg_bus.dbg_shift) begin
               dbg_bus.dbg_slot = 5'd3;
               dbg_bus.dbg_req  = 1'b1;
            end else begin
               dbg_bus.dbg_req = 1'b0;
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [4:0] tgt);
      dbg_bus.dbg_slot = tgt;
      dbg_bus.dbg_req  = 1'b1;
   endtask

   task automatic wait_slot(input int tgt);
      bit found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge MCLK);
         if (int'(slot) == tgt && !dbg_bus.dbg_busy) found = 1'b1;
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("[TB] FAIL wait_slot: slot %0d not reached, got %0d", tgt, slot);
      end
   endtask

   task automatic test_reset();
      int sync_cnt = 0;
      IC = 1'b0;
      dbg_bus.dbg_req  = 1'b0;
      dbg_bus.dbg_slot = 5'd0;
      repeat (3) @(negedge MCLK);
      compared++;
      if ({c1, c2, slot, sync, dbg_bus.dbg_load, dbg_bus.dbg_shift, dbg_bus.dbg_busy,
           dbg_bus.dbg_done, dbg_bus.dbg_err} !== 13'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: c1=%b c2=%b slot=%0d sync=%b busy=%b, want all 0",
                  c1, c2, slot, sync, dbg_bus.dbg_busy);
      end
      IC = 1'b1;
      for (int k = 0; k < 150; k++) begin
         logic [7:0] exp_v;
         #1;
         exp_v = {(k % CLK_DIV == 0), (k % CLK_DIV == CLK_DIV / 2), 5'(exp_slot(k)),
                  (exp_slot(k) == SLOTS - 1)};
         compared++;
         if ({c1, c2, slot, sync} !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL phase_slot cycle %0d: got c1=%b c2=%b slot=%0d sync=%b, want c1=%b c2=%b slot=%0d sync=%b",
                     k, c1, c2, slot, sync, exp_v[7], exp_v[6], exp_v[5:1], exp_v[0]);
         end
         if (k < SLOTS * CLK_DIV && sync) sync_cnt++;
         @(negedge MCLK);
      end
      compared++;
      if (sync_cnt != CLK_DIV) begin
         mismatched++;
         $display("[TB] FAIL sync_width: got %0d MCLK per frame, want %0d", sync_cnt, CLK_DIV);
      end
   endtask

   task automatic test_read(input int tgt, input int start_slot);
      int k0, exp_l;
      wait_slot(start_slot);
      k0    = mcount;
      exp_l = first_load(k0, tgt);
      applyStimulus(5'(tgt));
      @(negedge MCLK);
      compared++;
      if (dbg_bus.dbg_busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL busy_after_accept: got %b want 1", dbg_bus.dbg_busy);
      end
      dbg_bus.dbg_req = 1'b0;
      observe(exp_l - mcount + 80, 1'b0);
      compared++;
      if (load_first != exp_l || slot_at_load != tgt) begin
         mismatched++;
         $display("[TB] FAIL load_start slot %0d: got cycle %0d slot %0d, want cycle %0d slot %0d",
                  tgt, load_first, slot_at_load, exp_l, tgt);
      end
      compared++;
      if (load_cnt != CLK_DIV) begin
         mismatched++;
         $display("[TB] FAIL load_width: got %0d want %0d", load_cnt, CLK_DIV);
      end
      compared++;
      if (shift_first != exp_l + CLK_DIV || shift_cnt != DBG_WIDTH * CLK_DIV) begin
         mismatched++;
         $display("[TB] FAIL shift_window: got start %0d len %0d, want start %0d len %0d",
                  shift_first, shift_cnt, exp_l + CLK_DIV, DBG_WIDTH * CLK_DIV);
      end
      compared++;
      if (done_cnt != 1 || done_cycle != exp_l + CLK_DIV * (DBG_WIDTH + 1) || err_cnt != 0) begin
         mismatched++;
         $display("[TB] FAIL done_pulse: got count %0d at %0d err %0d, want 1 at %0d err 0",
                  done_cnt, done_cycle, err_cnt, exp_l + CLK_DIV * (DBG_WIDTH + 1));
      end
      compared++;
      if (bits !== 10'h2B3) begin
         mismatched++;
         $display("[TB] FAIL chain_bits: got %h want 2b3", bits);
      end
   endtask

   task automatic test_reject();
      @(negedge MCLK);
      applyStimulus(5'd24);
      @(negedge MCLK);
      compared++;
      if ({dbg_bus.dbg_busy, dbg_bus.dbg_done, dbg_bus.dbg_err} !== 3'b111) begin
         mismatched++;
         $display("[TB] FAIL reject_pulse: got busy/done/err %b%b%b want 111",
                  dbg_bus.dbg_busy, dbg_bus.dbg_done, dbg_bus.dbg_err);
      end
      dbg_bus.dbg_req = 1'b0;
      @(negedge MCLK);
      compared++;
      if ({dbg_bus.dbg_busy, dbg_bus.dbg_done, dbg_bus.dbg_err} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL reject_end: got busy/done/err %b%b%b want 000",
                  dbg_bus.dbg_busy, dbg_bus.dbg_done, dbg_bus.dbg_err);
      end
      observe(200, 1'b0);
      compared++;
      if (load_cnt != 0 || done_cnt != 0) begin
         mismatched++;
         $display("[TB] FAIL reject_quiet: got load %0d done %0d want 0 0", load_cnt, done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int k0, exp_l;
      @(negedge MCLK);
      k0    = mcount;
      exp_l = first_load(k0, 10);
      applyStimulus(5'd10);
      @(negedge MCLK);
      dbg_bus.dbg_req = 1'b0;
      observe(exp_l - mcount + 80, 1'b1);
      compared++;
      if (done_cnt != 1 || load_cnt != CLK_DIV) begin
         mismatched++;
         $display("[TB] FAIL ignore_rise: got done %0d load %0d want 1 %0d", done_cnt, load_cnt, CLK_DIV);
      end
      observe(200, 1'b0);
      compared++;
      if (load_cnt != 0 || done_cnt != 0 || dbg_bus.dbg_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL ignore_queue: got load %0d done %0d busy %b want 0 0 0",
                  load_cnt, done_cnt, dbg_bus.dbg_busy);
      end
   endtask

   task automatic test_abort();
      bit seen = 1'b0;
      @(negedge MCLK);
      applyStimulus(5'd12);
      @(negedge MCLK);
      dbg_bus.dbg_req = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge MCLK);
         if (dbg_bus.dbg_shift) seen = 1'b1;
      end
      compared++;
      if (!seen) begin
         mismatched++;
         $display("[TB] FAIL abort_shift_start: got shift %b want 1 within 400 MCLK", dbg_bus.dbg_shift);
      end
      repeat (14) @(negedge MCLK);
      #2 IC = 1'b0;
      #1;
      compared++;
      if ({c1, c2, slot, sync, dbg_bus.dbg_load, dbg_bus.dbg_shift, dbg_bus.dbg_busy,
           dbg_bus.dbg_done, dbg_bus.dbg_err} !== 13'd0) begin
         mismatched++;
         $display("[TB] FAIL abort_async: slot=%0d shift=%b busy=%b done=%b, want all 0",
                  slot, dbg_bus.dbg_shift, dbg_bus.dbg_busy, dbg_bus.dbg_done);
      end
      repeat (3) @(negedge MCLK);
      IC = 1'b1;
      #1;
      compared++;
      if ({c1, c2, slot, dbg_bus.dbg_busy} !== 8'b1000_0000) begin
         mismatched++;
         $display("[TB] FAIL abort_restart: got c1=%b c2=%b slot=%0d busy=%b, want 1 0 0 0",
                  c1, c2, slot, dbg_bus.dbg_busy);
      end
      observe(200, 1'b0);
      compared++;
      if (done_cnt != 0 || load_cnt != 0) begin
         mismatched++;
         $display("[TB] FAIL abort_no_done: got done %0d load %0d want 0 0", done_cnt, load_cnt);
      end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_read(5, 2);
      test_read(7, 7);
      test_reject();
      test_back_to_back();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
